// File: rtl/bus_pkg.sv
// Shared types and constants for the 8088 bus cycle controller and its arbiter.
package bus_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;

    typedef enum logic {
        leer     = 1'b0,
        escribir = 1'b1
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        T3,
        TW,
        T4
    } state_t;

    typedef enum logic {
        REQ_EU = 1'b0,
        REQ_PF = 1'b1
    } req_id_t;

endpackage

// File: rtl/bus_arbiter.sv
// EU-over-PF fixed-priority arbiter with a 2-bit starve counter that lets
// the prefetch queue win once after STARVE_MAX consecutive losses.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    arb_en,
    input  logic    eu_req,
    input  logic    pf_req,
    output logic    grant,
    output req_id_t grant_id
);

    logic [1:0] starve_reg;
    logic       pf_wins;

    always_comb begin
        pf_wins  = pf_req && (!eu_req || (starve_reg == 2'(STARVE_MAX)));
        grant    = arb_en && (eu_req || pf_req);
        grant_id = pf_wins ? REQ_PF : REQ_EU;
    end

    // Only an actual arbitration moves the counter; a PF loss is counted
    // solely when PF was asking at that moment.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_reg <= 2'd0;
        end else if (grant) begin
            if (pf_wins) begin
                starve_reg <= 2'd0;
            end else if (pf_req) begin
                starve_reg <= starve_reg + 2'd1;
            end
        end
    end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// T1-T4 bus cycle sequencer with EU/PF arbitration and latched cycle registers.
// Wait-state support (TW, mem_ready) is enabled by defining BUS_WAIT_STATE_EN.
module bus_cycle_ctrl #(
    parameter int STARVE_MAX = 3,
    parameter int ADDR_W     = bus_pkg::ADDR_W,
    parameter int DATA_W     = bus_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              eu_req,
    input  logic              eu_wr,
    input  logic [ADDR_W-1:0] eu_addr,
    input  logic [DATA_W-1:0] eu_wdata,
    input  logic              pf_req,
    input  logic [ADDR_W-1:0] pf_addr,
    output logic              eu_done,
    output logic              pf_done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] Direction,
    output logic              RD_WR,
    output logic [DATA_W-1:0] Data_drive,
    output logic              data_oe,
    input  logic [DATA_W-1:0] Data_in,
    input  logic              mem_ready,
    output logic              bus_busy
);
    import bus_pkg::*;

    state_t            state_reg, state_next;
    req_id_t           owner_reg;
    op_t               op_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              arb_en;
    logic              grant;
    req_id_t           grant_id;
    logic              capture;

    assign arb_en = (state_reg == IDLE) || (state_reg == T4);

    bus_arbiter #(.STARVE_MAX(STARVE_MAX)) u_arbiter (
        .clk      (clk),
        .reset    (reset),
        .arb_en   (arb_en),
        .eu_req   (eu_req),
        .pf_req   (pf_req),
        .grant    (grant),
        .grant_id (grant_id)
    );

`ifndef BUS_WAIT_STATE_EN
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: state_next = grant ? T1 : IDLE;
            T1:   state_next = T2;
            T2:   state_next = T3;
`ifdef BUS_WAIT_STATE_EN
            T3:   state_next = mem_ready ? T4 : TW;
            TW:   state_next = mem_ready ? T4 : TW;
`else
            T3:   state_next = T4;
            TW:   state_next = IDLE;
`endif
            T4:   state_next = grant ? T1 : IDLE;
            default: state_next = IDLE;
        endcase
        capture = (state_next == T4) && ((state_reg == T3) || (state_reg == TW));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            owner_reg <= REQ_EU;
            op_reg    <= leer;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                owner_reg <= grant_id;
                if (grant_id == REQ_PF) begin
                    op_reg    <= leer;
                    addr_reg  <= pf_addr;
                    wdata_reg <= '0;
                end else begin
                    op_reg    <= op_t'(eu_wr);
                    addr_reg  <= eu_addr;
                    wdata_reg <= eu_wdata;
                end
            end
            if (capture) begin
                rdata_reg <= Data_in;
            end
        end
    end

    // Bus-side outputs are forced low outside T1-T4 so an aborted cycle
    // leaves nothing on the bus.
    always_comb begin
        bus_busy   = (state_reg != IDLE);
        Direction  = bus_busy ? addr_reg : '0;
        RD_WR      = bus_busy && (op_reg == escribir);
        Data_drive = bus_busy ? wdata_reg : '0;
        data_oe    = (op_reg == escribir) &&
                     ((state_reg == T2) || (state_reg == T3) ||
                      (state_reg == TW) || (state_reg == T4));
        eu_done    = (state_reg == T4) && (owner_reg == REQ_EU);
        pf_done    = (state_reg == T4) && (owner_reg == REQ_PF);
        rdata      = rdata_reg;
    end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Self-checking bench for bus_cycle_ctrl: vector table, random transactions
// against a transaction-level model, and hand-written multi-cycle sequences.
module tb_bus_cycle_ctrl;

    localparam int STARVE_MAX = 3;
`ifdef BUS_WAIT_STATE_EN
    localparam bit WS = 1'b1;
`else
    localparam bit WS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        eu_req, eu_wr, pf_req, mem_ready;
    logic [19:0] eu_addr, pf_addr, Direction;
    logic [15:0] eu_wdata, rdata, Data_drive, Data_in;
    logic        eu_done, pf_done, RD_WR, data_oe, bus_busy;

    always #5 clk = ~clk;

    bus_cycle_ctrl #(.STARVE_MAX(STARVE_MAX), .ADDR_W(20), .DATA_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .eu_req     (eu_req),
        .eu_wr      (eu_wr),
        .eu_addr    (eu_addr),
        .eu_wdata   (eu_wdata),
        .pf_req     (pf_req),
        .pf_addr    (pf_addr),
        .eu_done    (eu_done),
        .pf_done    (pf_done),
        .rdata      (rdata),
        .Direction  (Direction),
        .RD_WR      (RD_WR),
        .Data_drive (Data_drive),
        .data_oe    (data_oe),
        .Data_in    (Data_in),
        .mem_ready  (mem_ready),
        .bus_busy   (bus_busy)
    );

    int    checks = 0;
    int    errors = 0;
    int    starve_m = 0;
    string cur_tag = "";

    typedef struct {
        int          mode;     // 0 EU only, 1 PF only, 2 both
        bit          wr;
        logic [19:0] ea;
        logic [15:0] wd;
        logic [19:0] pa;
        int          waits;
        logic [15:0] din;
        int          exp_win;  // 0 EU, 1 PF
        int          exp_lat;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s actual=%0h required=%0h", cur_tag, name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Arbitration model: EU preferred, PF after STARVE_MAX counted losses.
    function automatic int pick(input bit e, input bit p);
        if (p && (!e || starve_m == STARVE_MAX)) begin
            starve_m = 0;
            return 1;
        end
        if (p) starve_m++;
        return 0;
    endfunction

    function automatic int lat_of(input int waits);
        return WS ? 4 + waits : 4;
    endfunction

    // Starts from IDLE, one cycle after an edge; returns in IDLE.
    task automatic run_txn(input int mode, input bit wr, input logic [19:0] ea,
                           input logic [15:0] wd, input logic [19:0] pa, input int waits,
                           input logic [15:0] din, input int exp_win, input int lat);
        logic [19:0] exp_addr;
        bit          exp_wr;
        exp_addr = (exp_win == 1) ? pa : ea;
        exp_wr   = (exp_win == 0) ? wr : 1'b0;
        eu_req   = (mode != 1);
        pf_req   = (mode != 0);
        eu_wr    = wr;
        eu_addr  = ea;
        eu_wdata = wd;
        pf_addr  = pa;
        for (int k = 1; k <= lat + 1; k++) begin
            step();
            if (k == 1) begin
                eu_req   = 1'b0;
                pf_req   = 1'b0;
                eu_addr  = 20'($urandom);
                pf_addr  = 20'($urandom);
                eu_wdata = 16'($urandom);
                eu_wr    = 1'($urandom);
            end
            Data_in   = (k == lat - 1) ? din : 16'($urandom);
            mem_ready = (k >= 3) ? ((k - 3) >= waits) : 1'($urandom);
            chk("bus_busy", bus_busy, (k <= lat));
            chk("data_oe", data_oe, (exp_wr && k >= 2 && k <= lat));
            chk("eu_done", eu_done, (k == lat && exp_win == 0));
            chk("pf_done", pf_done, (k == lat && exp_win == 1));
            if (k <= lat) begin
                chk("Direction", Direction, exp_addr);
                chk("RD_WR", RD_WR, exp_wr);
                if (exp_wr) chk("Data_drive", Data_drive, wd);
            end
            if (k == lat && !exp_wr) chk("rdata", rdata, din);
        end
        $display("txn %s mode=%0d wr=%0d winner=%0s lat=%0d addr=%05h", cur_tag, mode, exp_wr,
                 exp_win ? "PF" : "EU", lat, exp_addr);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        starve_m = 0;
    endtask

    initial begin
        int exp_order[8];
        int g;
        int cyc;
        int w;
        exp_order = '{0, 0, 0, 1, 0, 0, 0, 1};
        reset = 1'b1; eu_req = 0; pf_req = 0; eu_wr = 0; eu_addr = 0; eu_wdata = 0;
        pf_addr = 0; Data_in = 0; mem_ready = 1;

        vecs[0] = '{0, 1'b0, 20'h12345, 16'h0000, 20'h00000, 0, 16'hBEEF, 0, 4};
        vecs[1] = '{0, 1'b1, 20'h0A000, 16'h5A5A, 20'h00000, 0, 16'h1111, 0, 4};
        vecs[2] = '{1, 1'b0, 20'h00000, 16'h0000, 20'h00F00, 2, 16'h1234, 1, lat_of(2)};
        vecs[3] = '{0, 1'b0, 20'hFFFFF, 16'h0000, 20'h00000, 3, 16'hC0DE, 0, lat_of(3)};
        vecs[4] = '{2, 1'b0, 20'h00111, 16'h0000, 20'h00222, 0, 16'hA001, 0, 4};
        vecs[5] = '{2, 1'b1, 20'h00333, 16'h7777, 20'h00444, 0, 16'hA002, 0, 4};
        vecs[6] = '{2, 1'b0, 20'h00555, 16'h0000, 20'h00666, 1, 16'hA003, 0, lat_of(1)};
        vecs[7] = '{2, 1'b1, 20'h00777, 16'h8888, 20'h00888, 0, 16'hA004, 1, 4};
        vecs[8] = '{1, 1'b1, 20'h00999, 16'h9999, 20'h00AAA, 0, 16'hA005, 1, 4};

        cur_tag = "reset";
        do_reset();
        chk("bus_busy", bus_busy, 0);
        chk("Direction", Direction, 0);
        chk("RD_WR", RD_WR, 0);
        chk("Data_drive", Data_drive, 0);
        chk("data_oe", data_oe, 0);
        chk("eu_done", eu_done, 0);
        chk("pf_done", pf_done, 0);
        chk("rdata", rdata, 0);

        for (int i = 0; i < 9; i++) begin
            cur_tag = $sformatf("vec%0d", i);
            w = pick(vecs[i].mode != 1, vecs[i].mode != 0);
            run_txn(vecs[i].mode, vecs[i].wr, vecs[i].ea, vecs[i].wd, vecs[i].pa,
                    vecs[i].waits, vecs[i].din, vecs[i].exp_win, vecs[i].exp_lat);
        end

        for (int i = 0; i < 40; i++) begin
            int          mode;
            int          waits;
            logic [19:0] ea, pa;
            logic [15:0] wd, din;
            bit          wr;
            cur_tag = $sformatf("rnd%0d", i);
            mode  = int'($urandom_range(0, 2));
            waits = int'($urandom_range(0, 3));
            wr    = 1'($urandom);
            ea    = 20'($urandom);
            pa    = 20'($urandom);
            wd    = 16'($urandom);
            din   = 16'($urandom);
            w     = pick(mode != 1, mode != 0);
            run_txn(mode, wr, ea, wd, pa, waits, din, w, lat_of(waits));
        end

        // Continuous requests from both sides: fixed grant order, no idle gaps.
        cur_tag = "cont";
        do_reset();
        mem_ready = 1'b1;
        eu_wr = 1'b0; eu_addr = 20'h0EEEE; pf_addr = 20'h0FFFF;
        eu_req = 1'b1; pf_req = 1'b1;
        g = 0; cyc = 0;
        while (g < 8 && cyc < 60) begin
            step();
            cyc++;
            chk("bus_busy", bus_busy, 1);
            if (eu_done || pf_done) begin
                chk("order_eu", eu_done, (exp_order[g] == 0));
                chk("order_pf", pf_done, (exp_order[g] == 1));
                chk("spacing", cyc, 4 * (g + 1));
                chk("Direction", Direction, exp_order[g] ? 20'h0FFFF : 20'h0EEEE);
                $display("txn cont grant=%0d winner=%0s cycle=%0d", g,
                         pf_done ? "PF" : "EU", cyc);
                g++;
                if (g == 8) begin
                    eu_req = 1'b0;
                    pf_req = 1'b0;
                end
            end
        end
        chk("grants", g, 8);
        eu_req = 1'b0; pf_req = 1'b0;
        step();
        chk("idle_after", bus_busy, 0);

        // Reset in T3 of a write, with a nonzero starve count beforehand.
        cur_tag = "rst_t3";
        w = pick(1, 1);
        run_txn(2, 1'b0, 20'h01010, 16'h0, 20'h02020, 0, 16'h3C3C, w, 4);
        eu_req = 1'b1; pf_req = 1'b1; eu_wr = 1'b1; eu_addr = 20'h03030; eu_wdata = 16'hA5A5;
        w = pick(1, 1);
        step();
        eu_req = 1'b0; pf_req = 1'b0;
        step();
        step();
        chk("data_oe_t3", data_oe, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        starve_m = 0;
        chk("bus_busy", bus_busy, 0);
        chk("data_oe", data_oe, 0);
        chk("RD_WR", RD_WR, 0);
        chk("Direction", Direction, 0);
        chk("Data_drive", Data_drive, 0);
        for (int k = 0; k < 4; k++) begin
            chk("no_done", {30'd0, eu_done, pf_done}, 0);
            step();
        end
        $display("txn rst_t3 aborted write addr=03030");
        for (int i = 0; i < 4; i++) begin
            cur_tag = $sformatf("post_rst%0d", i);
            w = pick(1, 1);
            run_txn(2, 1'b0, 20'h04040 + 20'(i), 16'h0, 20'h05050 + 20'(i), 0,
                    16'($urandom), w, 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
